encryption_engine_arbiter: RTL and testbench

Shares one `data_encryption_module` instance among NUM_REQ point-cloud producers in the LiDAR point cloud assembler, for example per-laser-bank packers. It accepts one 512-bit frame at a time through a valid/ready port, selects the producer by round-robin, and sequences the engine's `valid_in`/`valid_out` protocol. It returns the encrypted frame with the originating requester ID over a valid/ready response port. A watchdog terminates a hung engine transaction with an error response.

---
 rtl/encryption_engine_arbiter_pkg.sv | 22 ++
 rtl/encryption_engine_arbiter_if.sv | 36 +++
 rtl/encryption_engine_arbiter_rr_arbiter.sv | 32 +++
 rtl/encryption_engine_arbiter.sv | 107 ++++++++++
 tb/tb_encryption_engine_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/encryption_engine_arbiter_pkg.sv
// Shared types and helpers for the encryption engine arbiter.
package enc_arb_pkg;

  localparam int unsigned DATA_W_DEF = 512;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } arb_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/encryption_engine_arbiter_if.sv
// Requester, engine and response signals of the encryption engine arbiter.
interface encryption_engine_arbiter_if import enc_arb_pkg::*; #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DATA_W_DEF
) ();

  localparam int unsigned ID_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      eng_valid_in;
  logic [DATA_W-1:0]         eng_point_cloud;
  logic [DATA_W-1:0]         eng_encrypted_data;
  logic                      eng_valid_out;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_id;
  logic                      rsp_err;
  logic                      busy;

  // master: the arbiter itself; slave: requesters, engine and response consumer
  modport master (
    input  req_valid, req_data, eng_encrypted_data, eng_valid_out, rsp_ready,
    output req_ready, eng_valid_in, eng_point_cloud, rsp_valid, rsp_data,
           rsp_id, rsp_err, busy
  );

  modport slave (
    output req_valid, req_data, eng_encrypted_data, eng_valid_out, rsp_ready,
    input  req_ready, eng_valid_in, eng_point_cloud, rsp_valid, rsp_data,
           rsp_id, rsp_err, busy
  );

endinterface

// File: rtl/encryption_engine_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request after the pointer, wrapping.
module rr_arbiter import enc_arb_pkg::*; #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx
);

  always_comb begin : p_pick
    logic            w_found;
    logic [ID_W-1:0] w_cand;
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    if (i_en) begin
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
        w_cand = ID_W'((32'(i_ptr) + off) % NUM_REQ);
        if (!w_found && i_req[w_cand]) begin
          w_found         = 1'b1;
          o_grant[w_cand] = 1'b1;
          o_idx           = w_cand;
        end
      end
    end
  end

endmodule

// File: rtl/encryption_engine_arbiter.sv
// Shares one encryption engine among NUM_REQ frame producers, one transaction
// in flight, with a watchdog that aborts a hung engine with an error response.
module encryption_engine_arbiter import enc_arb_pkg::*; #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                       clk,
  input logic                       reset,
  encryption_engine_arbiter_if.master bus
);

  localparam int unsigned ID_W = idx_w(NUM_REQ);
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_t        r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_err;
  logic              r_vin;
  logic [WD_W-1:0]   r_wd;

  logic              w_idle;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]   w_idx;
  logic              w_accept;
  logic [DATA_W-1:0] w_frame;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = |w_grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_idle),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_frame = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) w_frame = bus.req_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= ID_W'(NUM_REQ - 1);
      r_id       <= '0;
      r_pc       <= '0;
      r_rsp_data <= '0;
      r_err      <= 1'b0;
      r_vin      <= 1'b0;
      r_wd       <= '0;
    end else begin
      r_vin <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= ISSUE;
            r_pc    <= w_frame;
            r_id    <= w_idx;
            r_ptr   <= w_idx;
            r_vin   <= 1'b1;
          end
        end
        ISSUE: begin
          r_state <= WAIT;
          r_wd    <= '0;
        end
        WAIT: begin
          // valid_out is stale-high outside WAIT; a completion on the expiry cycle still wins
          if (bus.eng_valid_out) begin
            r_rsp_data <= bus.eng_encrypted_data;
            r_err      <= 1'b0;
            r_state    <= RESP;
          end else if (r_wd == WD_LAST) begin
            r_rsp_data <= '0;
            r_err      <= 1'b1;
            r_state    <= RESP;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready       = w_grant;
  assign bus.eng_valid_in    = r_vin;
  assign bus.eng_point_cloud = r_pc;
  assign bus.rsp_valid       = (r_state == RESP);
  assign bus.rsp_data        = r_rsp_data;
  assign bus.rsp_id          = r_id;
  assign bus.rsp_err         = r_err;
  assign bus.busy            = !w_idle;

endmodule

// File: tb/tb_encryption_engine_arbiter.sv
// Bench for encryption_engine_arbiter: engine model with programmable latency,
// table-driven transactions plus round-robin, backpressure and reset sequences.
module tb_encryption_engine_arbiter;
  import enc_arb_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 512;
  localparam int unsigned TO = 16;
  localparam logic [DW-1:0] KEY = {64{8'hA5}};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  encryption_engine_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  encryption_engine_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] seed;
    int          lat;
    logic [1:0]  exp_id;
    logic        exp_err;
    int          delay;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic       err;
  } pend_t;

  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  pend_t pend[$];
  exp_t  sb[$];
  vec_t  tbl[10];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int acc_cyc = 0;
  int hs_cyc = 0;
  int exp_lat = 0;
  int rv_cnt = 0;
  int cur_lat = 2;
  logic [DW-1:0] exp_frame = '0;
  logic prev_rv = 1'b0;
  logic e_preload = 1'b0;
  logic [7:0] e_cnt;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Engine: clears valid_out at the issue edge, raises it cur_lat cycles later, holds it high
  always @(posedge clk) begin
    if (reset) begin
      e_cnt                  <= '0;
      bus.eng_valid_out      <= 1'b0;
      bus.eng_encrypted_data <= '0;
    end else if (e_preload) begin
      bus.eng_valid_out      <= 1'b1;
      bus.eng_encrypted_data <= {16{32'hDEADBEEF}};
    end else if (bus.eng_valid_in) begin
      bus.eng_valid_out <= 1'b0;
      e_cnt             <= 8'(cur_lat);
    end else if (e_cnt != 0) begin
      e_cnt <= e_cnt - 8'd1;
      if (e_cnt == 8'd1) begin
        bus.eng_valid_out      <= 1'b1;
        bus.eng_encrypted_data <= bus.eng_point_cloud ^ KEY;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      pend_t p;
      exp_t  e;
      int    gid;
      chk("req_ready_onehot", 32'($countones(bus.req_ready)) <= 1, 1);
      if (|(bus.req_valid & bus.req_ready)) begin
        acc_cnt++;
        acc_cyc = cyc;
        if (pend.size() == 0) chk("accept_unexpected", pend.size(), 1);
        else begin
          p = pend.pop_front();
          gid = 0;
          for (int i = 0; i < NR; i++) if (bus.req_ready[i]) gid = i;
          chk("grant_id", gid, p.id);
          exp_frame = bus.req_data[32'(p.id)*DW +: DW];
          e.id   = p.id;
          e.err  = p.err;
          e.data = p.err ? '0 : (exp_frame ^ KEY);
          sb.push_back(e);
          exp_lat = p.err ? TO + 2 : cur_lat + 3;
        end
      end
      if (bus.eng_valid_in) begin
        chk("issue_cycle", cyc - acc_cyc, 1);
        chk("issue_frame", bus.eng_point_cloud, exp_frame);
      end
      if (bus.rsp_valid) begin
        rv_cnt++;
        chk("no_grant_in_resp", bus.req_ready, 0);
        if (!prev_rv) chk("rsp_latency", cyc - acc_cyc, exp_lat);
        if (sb.size() == 0) chk("rsp_unexpected", sb.size(), 1);
        else begin
          chk("rsp_id", bus.rsp_id, sb[0].id);
          chk("rsp_data", bus.rsp_data, sb[0].data);
          chk("rsp_err", bus.rsp_err, sb[0].err);
          if (bus.rsp_ready) begin
            void'(sb.pop_front());
            hs_cyc = cyc;
          end
        end
      end
      prev_rv = bus.rsp_valid;
    end else begin
      prev_rv = 1'b0;
    end
  end

  task automatic set_data(input logic [31:0] seed);
    for (int i = 0; i < NR; i++)
      bus.req_data[i*DW +: DW] = {{15{seed}}, seed + 32'(i) - 32'd1};
  endtask

  task automatic wait_accept(input int start, input int bound);
    int n = 0;
    while (acc_cnt == start && n < bound) begin
      @(posedge clk);
      n++;
    end
    chk("accept_seen", acc_cnt - start, 1);
  endtask

  task automatic wait_rsp_valid(input int bound);
    int n = 0;
    while (!bus.rsp_valid && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_seen", bus.rsp_valid, 1);
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drained", sb.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_valid_in"}, bus.eng_valid_in, 0);
    chk({tag, "_point_cloud"}, bus.eng_point_cloud, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 0);
    chk({tag, "_rsp_id"}, bus.rsp_id, 0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int start;
    set_data(v.seed);
    cur_lat = v.lat;
    pend.push_back('{v.exp_id, v.exp_err});
    @(posedge clk); #1;
    bus.req_valid = v.mask;
    start = acc_cnt;
    wait_accept(start, 40);
    #1 bus.req_valid = '0;
    wait_rsp_valid(40);
    repeat (v.delay) begin @(posedge clk); #1; end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int start;
    int t_prev;
    tbl[0] = '{4'b0100, 32'h0000_0000, 2,   2'd2, 1'b0, 0};
    tbl[1] = '{4'b1111, 32'h1111_1111, 2,   2'd3, 1'b0, 0};
    tbl[2] = '{4'b1111, 32'h2222_2222, 2,   2'd0, 1'b0, 0};
    tbl[3] = '{4'b1111, 32'h3333_3333, 2,   2'd1, 1'b0, 3};
    tbl[4] = '{4'b0001, 32'h4444_4444, 255, 2'd0, 1'b1, 0};
    tbl[5] = '{4'b1001, 32'h5555_5555, 2,   2'd3, 1'b0, 0};
    tbl[6] = '{4'b0110, 32'h6666_6666, 15,  2'd1, 1'b0, 0};
    tbl[7] = '{4'b0011, 32'h7777_7777, 16,  2'd0, 1'b1, 0};
    tbl[8] = '{4'b0110, 32'h8888_8888, 2,   2'd1, 1'b0, 1};
    tbl[9] = '{4'b1100, 32'h9999_9999, 5,   2'd2, 1'b0, 0};

    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_zero_outputs("reset");

    // stale valid_out already high in IDLE before the first issue
    e_preload = 1'b1;
    @(posedge clk); #1;
    e_preload = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);
    wait_drain(40);
    chk("pending_grants", pend.size(), 0);

    // backpressure: rsp_ready low 10 cycles with all requesters waiting
    set_data(32'hABCD_0000);
    cur_lat = 2;
    pend.push_back('{2'd3, 1'b0});
    pend.push_back('{2'd0, 1'b0});
    @(posedge clk); #1;
    bus.req_valid = 4'b1111;
    wait_rsp_valid(40);
    repeat (10) begin @(posedge clk); #1; end
    bus.rsp_ready = 1'b1;
    start = acc_cnt;
    wait_accept(start, 10);
    chk("accept_after_handshake", acc_cyc - hs_cyc, 1);
    #1 bus.req_valid = '0;
    wait_drain(40);
    bus.rsp_ready = 1'b0;

    // reset while the engine is working
    pend.push_back('{2'd1, 1'b0});
    @(posedge clk); #1;
    bus.req_valid = 4'b0010;
    start = acc_cnt;
    wait_accept(start, 10);
    #1 bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1 chk("in_wait_busy", bus.busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    pend.delete();
    check_zero_outputs("midreset");
    rv_cnt = 0;
    repeat (25) @(posedge clk);
    #1 chk("no_rsp_after_reset", rv_cnt, 0);

    // continuous requests: grants rotate from requester 0 at a 6-cycle period
    set_data(32'hC0DE_0000);
    cur_lat = 2;
    for (int k = 0; k < 5; k++) pend.push_back('{2'(k % NR), 1'b0});
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      start = acc_cnt;
      wait_accept(start, 20);
      if (k > 0) chk("rr_period", acc_cyc - t_prev, 6);
      t_prev = acc_cyc;
    end
    #1 bus.req_valid = '0;
    wait_drain(40);
    bus.rsp_ready = 1'b0;

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
